// File: rtl/cpu_pkg.sv
// Shared definitions for the bus-CPU control unit: opcodes, IR field offsets,
// sequencer state encoding and the bundle of datapath strobes.
package cpu_pkg;

  localparam int OPC_W      = 5;
  localparam int ALUOP_W    = 5;
  localparam int IR_OPC_LSB = 27;
  localparam int IR_RA_LSB  = 23;
  localparam int IR_RB_LSB  = 19;
  localparam int IR_RC_LSB  = 15;
  localparam int IR_C_W     = 19;

  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_SHR  = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SHL  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_ROR  = 5'b00111;
  localparam logic [OPC_W-1:0] OPC_ROL  = 5'b01000;
  localparam logic [OPC_W-1:0] OPC_AND  = 5'b01001;
  localparam logic [OPC_W-1:0] OPC_OR   = 5'b01010;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(OPC_ADD);

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_T0     = 4'd1,
    ST_T1     = 4'd2,
    ST_T2     = 4'd3,
    ST_T3     = 4'd4,
    ST_T4     = 4'd5,
    ST_T5     = 4'd6,
    ST_T6     = 4'd7,
    ST_T7     = 4'd8,
    ST_HALTED = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP  = 3'd0,
    CLS_ALU  = 3'd1,
    CLS_ADDI = 3'd2,
    CLS_LD   = 3'd3,
    CLS_ST   = 3'd4,
    CLS_HALT = 3'd5
  } iclass_e;

  typedef struct packed {
    logic               run;
    logic               pc_out;
    logic               pc_in;
    logic               inc_pc;
    logic               mar_in;
    logic               mdr_in;
    logic               mdr_out;
    logic               read;
    logic               write;
    logic               ir_in;
    logic               y_in;
    logic               z_in;
    logic               zlow_out;
    logic               gra;
    logic               grb;
    logic               grc;
    logic               r_in;
    logic               r_out;
    logic               ba_out;
    logic               c_out;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic logic [OPC_W-1:0] ir_opcode(input logic [31:0] ir);
    return ir[IR_OPC_LSB +: OPC_W];
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to instruction-class decode. LDI and every unlisted opcode behave
// as NOP: the sequencer fetches them and writes nothing.
module ctrl_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output iclass_e          iclass
);

  always_comb begin
    iclass = CLS_NOP;
    case (opcode)
      OPC_ADD, OPC_SUB, OPC_SHR, OPC_SHL,
      OPC_ROR, OPC_ROL, OPC_AND, OPC_OR:  iclass = CLS_ALU;
      OPC_ADDI:                           iclass = CLS_ADDI;
      OPC_LD:                             iclass = CLS_LD;
      OPC_ST:                             iclass = CLS_ST;
      OPC_HALT:                           iclass = CLS_HALT;
      OPC_NOP, OPC_LDI:                   iclass = CLS_NOP;
      default:                            iclass = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: T0..T7 sequencer with memory wait states.
// Strobes are registered from the next state, so they change only on Clock.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [31:0]        IR,
  input  logic               Mem_ready,
  output logic               Run,
  output logic               PCout,
  output logic               PCin,
  output logic               IncPC,
  output logic               MARin,
  output logic               MDRin,
  output logic               MDRout,
  output logic               Read,
  output logic               Write,
  output logic               IRin,
  output logic               Yin,
  output logic               Zin,
  output logic               Zlowout,
  output logic               Gra,
  output logic               Grb,
  output logic               Grc,
  output logic               Rin,
  output logic               Rout,
  output logic               BAout,
  output logic               Cout,
  output logic [ALUOP_W-1:0] alu_op
);

  state_e           state_reg, state_next;
  iclass_e          cls_reg, cls_next, dec_cls;
  logic [OPC_W-1:0] opc_reg, opc_next, ir_opc;
  ctrl_t            ctrl_reg, ctrl_next;
  logic             unused_ir_bits;

  assign ir_opc         = ir_opcode(IR);
  assign unused_ir_bits = ^IR[IR_OPC_LSB-1:0];

  ctrl_decode u_decode (
    .opcode (ir_opc),
    .iclass (dec_cls)
  );

  function automatic ctrl_t strobes(input state_e st, input iclass_e cls,
                                    input logic [OPC_W-1:0] opc, input logic pc_first);
    ctrl_t c;
    c     = CTRL_IDLE;
    c.run = 1'b1;
    case (st)
      ST_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
        c.alu_op = ALU_ADD;
      end
      ST_T1: begin
        c.zlow_out = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1; c.pc_in = pc_first;
      end
      ST_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      ST_T3: begin
        if (cls inside {CLS_ALU, CLS_ADDI}) begin
          c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
        end else if (cls inside {CLS_LD, CLS_ST}) begin
          c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
        end
      end
      ST_T4: begin
        c.z_in = 1'b1;
        if (cls == CLS_ALU) begin
          c.grc = 1'b1; c.r_out = 1'b1; c.alu_op = ALUOP_W'(opc);
        end else begin
          c.c_out = 1'b1; c.alu_op = ALU_ADD;
        end
      end
      ST_T5: begin
        c.zlow_out = 1'b1;
        if (cls inside {CLS_ALU, CLS_ADDI}) begin
          c.gra = 1'b1; c.r_in = 1'b1;
        end else begin
          c.mar_in = 1'b1;
        end
      end
      ST_T6: begin
        c.mdr_in = 1'b1;
        if (cls == CLS_LD) c.read = 1'b1;
        else begin
          c.gra = 1'b1; c.r_out = 1'b1;
        end
      end
      ST_T7: begin
        if (cls == CLS_LD) begin
          c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
        end else begin
          c.write = 1'b1;
        end
      end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

  // The class is captured on the T2->T3 edge and held for the rest of the instruction.
  always_comb begin
    cls_next = (state_reg == ST_T2) ? dec_cls : cls_reg;
    opc_next = (state_reg == ST_T2) ? ir_opc  : opc_reg;
  end

  always_comb begin
    state_next = ST_RST;
    case (state_reg)
      ST_RST: state_next = ST_T0;
      ST_T0:  state_next = ST_T1;
      ST_T1:  state_next = Mem_ready ? ST_T2 : ST_T1;
      ST_T2:  state_next = ST_T3;
      ST_T3: begin
        case (cls_reg)
          CLS_ALU, CLS_ADDI, CLS_LD, CLS_ST: state_next = ST_T4;
          CLS_HALT:                          state_next = ST_HALTED;
          default:                           state_next = ST_T0;
        endcase
      end
      ST_T4:  state_next = ST_T5;
      ST_T5:  state_next = (cls_reg inside {CLS_LD, CLS_ST}) ? ST_T6 : ST_T0;
      ST_T6: begin
        if (cls_reg == CLS_LD) state_next = Mem_ready ? ST_T7 : ST_T6;
        else                   state_next = ST_T7;
      end
      ST_T7: begin
        if (cls_reg == CLS_ST) state_next = Mem_ready ? ST_T0 : ST_T7;
        else                   state_next = ST_T0;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RST;
    endcase
  end

  // PCin only on entry to T1 from T0, never while T1 waits on memory.
  assign ctrl_next = strobes(state_next, cls_next, opc_next, state_reg == ST_T0);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_reg <= ST_RST;
      cls_reg   <= CLS_NOP;
      opc_reg   <= '0;
      ctrl_reg  <= CTRL_IDLE;
    end else begin
      state_reg <= state_next;
      cls_reg   <= cls_next;
      opc_reg   <= opc_next;
      ctrl_reg  <= ctrl_next;
    end
  end

  assign Run     = ctrl_reg.run;
  assign PCout   = ctrl_reg.pc_out;
  assign PCin    = ctrl_reg.pc_in;
  assign IncPC   = ctrl_reg.inc_pc;
  assign MARin   = ctrl_reg.mar_in;
  assign MDRin   = ctrl_reg.mdr_in;
  assign MDRout  = ctrl_reg.mdr_out;
  assign Read    = ctrl_reg.read;
  assign Write   = ctrl_reg.write;
  assign IRin    = ctrl_reg.ir_in;
  assign Yin     = ctrl_reg.y_in;
  assign Zin     = ctrl_reg.z_in;
  assign Zlowout = ctrl_reg.zlow_out;
  assign Gra     = ctrl_reg.gra;
  assign Grb     = ctrl_reg.grb;
  assign Grc     = ctrl_reg.grc;
  assign Rin     = ctrl_reg.r_in;
  assign Rout    = ctrl_reg.r_out;
  assign BAout   = ctrl_reg.ba_out;
  assign Cout    = ctrl_reg.c_out;
  assign alu_op  = ctrl_reg.alu_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-cycle strobe sequences from a step-list
// model of each instruction, a vector table of totals, reset and random runs.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic [31:0] IR;
  logic        Mem_ready;
  logic        Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
  logic        Yin, Zin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
  logic [4:0]  alu_op;

  control_sequencer dut (
    .Clock(Clock), .Reset_n(Reset_n), .IR(IR), .Mem_ready(Mem_ready),
    .Run(Run), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout), .alu_op(alu_op)
  );

  always #5 Clock = ~Clock;

  localparam logic [24:0] M_RUN  = 25'd1 << 24, M_PCOUT = 25'd1 << 23, M_PCIN  = 25'd1 << 22;
  localparam logic [24:0] M_INC  = 25'd1 << 21, M_MARIN = 25'd1 << 20, M_MDRIN = 25'd1 << 19;
  localparam logic [24:0] M_MDRO = 25'd1 << 18, M_READ  = 25'd1 << 17, M_WRITE = 25'd1 << 16;
  localparam logic [24:0] M_IRIN = 25'd1 << 15, M_YIN   = 25'd1 << 14, M_ZIN   = 25'd1 << 13;
  localparam logic [24:0] M_ZLOW = 25'd1 << 12, M_GRA   = 25'd1 << 11, M_GRB   = 25'd1 << 10;
  localparam logic [24:0] M_GRC  = 25'd1 << 9,  M_RIN   = 25'd1 << 8,  M_ROUT  = 25'd1 << 7;
  localparam logic [24:0] M_BA   = 25'd1 << 6,  M_COUT  = 25'd1 << 5;
  localparam logic [24:0] A_ADD  = 25'd3;

  int n_cmp = 0;
  int n_err = 0;

  logic [24:0] exp_q[$];
  bit          rdy_q[$];

  typedef struct {
    logic [31:0] ir;
    int fw, mw, cyc, rin, rd, wr;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [24:0] dut_word();
    return {Run, PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin,
            Yin, Zin, Zlowout, Gra, Grb, Grc, Rin, Rout, BAout, Cout, alu_op};
  endfunction

  task automatic check(input string nm, input logic [24:0] got, input logic [24:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Instruction kinds: 0 no-op, 1 reg-reg ALU, 2 addi, 3 load, 4 store, 5 halt.
  function automatic int kind_of(input logic [4:0] opc);
    case (opc)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b01010: return 1;
      5'b01011: return 2;
      5'b00000: return 3;
      5'b00010: return 4;
      5'b11011: return 5;
      default:  return 0;
    endcase
  endfunction

  // rdy: 0/1 forced, 2 = don't care (randomised)
  task automatic step(input logic [24:0] w, input int rdy);
    exp_q.push_back(w);
    rdy_q.push_back(rdy == 2 ? 1'($urandom_range(0, 1)) : 1'(rdy));
  endtask

  task automatic build(input logic [31:0] ir, input int fw, input int mw);
    logic [4:0] opc;
    int k;
    opc = ir[31:27];
    k   = kind_of(opc);
    step(M_RUN | M_PCOUT | M_MARIN | M_INC | M_ZIN | A_ADD, 2);
    for (int w = 0; w <= fw; w++)
      step(M_RUN | M_ZLOW | M_READ | M_MDRIN | (w == 0 ? M_PCIN : 25'd0), w == fw ? 1 : 0);
    step(M_RUN | M_MDRO | M_IRIN, 2);
    case (k)
      1, 2: begin
        step(M_RUN | M_GRB | M_ROUT | M_YIN, 2);
        if (k == 1) step(M_RUN | M_GRC | M_ROUT | M_ZIN | 25'(opc), 2);
        else        step(M_RUN | M_COUT | M_ZIN | A_ADD, 2);
        step(M_RUN | M_ZLOW | M_GRA | M_RIN, 2);
      end
      3, 4: begin
        step(M_RUN | M_GRB | M_BA | M_YIN, 2);
        step(M_RUN | M_COUT | M_ZIN | A_ADD, 2);
        step(M_RUN | M_ZLOW | M_MARIN, 2);
        if (k == 3) begin
          for (int w = 0; w <= mw; w++) step(M_RUN | M_READ | M_MDRIN, w == mw ? 1 : 0);
          step(M_RUN | M_MDRO | M_GRA | M_RIN, 2);
        end else begin
          step(M_RUN | M_GRA | M_ROUT | M_MDRIN, 2);
          for (int w = 0; w <= mw; w++) step(M_RUN | M_WRITE, w == mw ? 1 : 0);
        end
      end
      5: begin
        step(M_RUN, 2);
        for (int i = 0; i < 3; i++) step(25'd0, 2);
      end
      default: step(M_RUN, 2);
    endcase
  endtask

  task automatic run_instr(input string nm, input logic [31:0] ir, input int fw, input int mw,
                           output int n_run, output int n_rin, output int n_rd, output int n_wr);
    logic [24:0] got;
    exp_q.delete();
    rdy_q.delete();
    build(ir, fw, mw);
    n_run = 0; n_rin = 0; n_rd = 0; n_wr = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge Clock);
      if (i == 0) IR = ir;
      Mem_ready = rdy_q[i];
      got = dut_word();
      n_run += int'(got[24]);
      n_rin += int'(got[8]);
      n_rd  += int'(got[17]);
      n_wr  += int'(got[16]);
      check($sformatf("%s ir=%h cyc%0d", nm, ir, i), got, exp_q[i]);
    end
  endtask

  initial begin
    int nr, ni, nd, nw;
    logic [31:0] r;
    logic [4:0]  opc;

    tbl[0]  = '{32'h4A920000, 0, 0, 6,  1, 1, 0};
    tbl[1]  = '{32'h4A920000, 3, 0, 9,  1, 4, 0};
    tbl[2]  = '{32'h00900065, 0, 0, 8,  1, 2, 0};
    tbl[3]  = '{32'h10900065, 0, 2, 10, 0, 1, 3};
    tbl[4]  = '{32'h59100007, 1, 0, 7,  1, 2, 0};
    tbl[5]  = '{32'hD0000000, 0, 0, 4,  0, 1, 0};
    tbl[6]  = '{32'hF8000000, 2, 0, 6,  0, 3, 0};
    tbl[7]  = '{32'h00900065, 1, 2, 11, 1, 5, 0};
    tbl[8]  = '{32'h20000000, 2, 0, 8,  1, 3, 0};
    tbl[9]  = '{32'h08000000, 0, 0, 4,  0, 1, 0};
    tbl[10] = '{32'hD8000000, 0, 0, 4,  0, 1, 0};

    Reset_n   = 1'b0;
    Mem_ready = 1'b0;
    IR        = 32'h0;
    repeat (2) @(negedge Clock);
    check("reset_state", dut_word(), 25'd0);
    Reset_n = 1'b1;

    // Reset asserted in the middle of T4 of an AND clears strobes without a clock edge.
    IR        = 32'h4A920000;
    Mem_ready = 1'b1;
    repeat (5) @(negedge Clock);
    check("and_t4", dut_word(), M_RUN | M_GRC | M_ROUT | M_ZIN | 25'b01001);
    #2 Reset_n = 1'b0;
    #1 check("async_reset", dut_word(), 25'd0);
    @(negedge Clock);
    check("held_reset", dut_word(), 25'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_instr($sformatf("vec%0d", i), tbl[i].ir, tbl[i].fw, tbl[i].mw, nr, ni, nd, nw);
      check_int($sformatf("vec%0d run_cycles", i), nr, tbl[i].cyc);
      check_int($sformatf("vec%0d rin_cycles", i), ni, tbl[i].rin);
      check_int($sformatf("vec%0d read_cycles", i), nd, tbl[i].rd);
      check_int($sformatf("vec%0d write_cycles", i), nw, tbl[i].wr);
    end

    // Halted machine restarts only through reset.
    @(negedge Clock);
    check("still_halted", dut_word(), 25'd0);
    Reset_n = 1'b0;
    @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      r   = $urandom();
      opc = 5'($urandom_range(0, 31));
      if (opc == 5'b11011) opc = 5'b00011;
      run_instr($sformatf("rnd%0d", i), {opc, r[26:0]}, int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), nr, ni, nd, nw);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
